// File: rtl/max_unpooling_if.sv
// Handshake bundle for max_unpooling: pooled pixel/index in, unpooled stream out.
interface max_unpooling_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned KERNEL_DIM = 3
);
  localparam int unsigned WIN_SIZE  = KERNEL_DIM * KERNEL_DIM;
  localparam int unsigned IDX_WIDTH = (WIN_SIZE > 1) ? $clog2(WIN_SIZE) : 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_pixel;
  logic [IDX_WIDTH-1:0]  in_index;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_pixel;
  logic                  out_last;
  logic                  err_index;

  // Producer of pooled pixels / consumer of the unpooled stream
  modport master (
    output in_valid, in_pixel, in_index, out_ready,
    input  in_ready, out_valid, out_pixel, out_last, err_index
  );

  // The unpooling block itself
  modport slave (
    input  in_valid, in_pixel, in_index, out_ready,
    output in_ready, out_valid, out_pixel, out_last, err_index
  );
endinterface

// File: rtl/max_unpooling.sv
// Streaming max-unpooling: expands one pooled pixel + argmax index into a
// KERNEL_DIM*KERNEL_DIM row-major stream, value at the argmax slot, zero elsewhere.
// Optional feature: define MAX_UNPOOL_PREFETCH_EN for a one-entry pending
// register that allows back-to-back windows without an idle bubble.
module max_unpooling #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned KERNEL_DIM = 3
) (
  input  logic              clk,
  input  logic              rst,
  max_unpooling_if.slave    bus
);
  localparam int unsigned WIN_SIZE  = KERNEL_DIM * KERNEL_DIM;
  localparam int unsigned IDX_WIDTH = (WIN_SIZE > 1) ? $clog2(WIN_SIZE) : 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  pos_q, pos_d;
  logic [DATA_WIDTH-1:0] pix_q, pix_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  err_q, err_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_pixel_q, out_pixel_d;
  logic                  out_last_q, out_last_d;
  logic                  in_ready_q, in_ready_d;
`ifdef MAX_UNPOOL_PREFETCH_EN
  logic                  pend_full_q, pend_full_d;
  logic [DATA_WIDTH-1:0] pend_pix_q, pend_pix_d;
  logic [IDX_WIDTH-1:0]  pend_idx_q, pend_idx_d;
`endif

  logic in_fire;
  logic out_fire;
  logic last_fire;

  assign in_fire   = bus.in_valid && in_ready_q;
  assign out_fire  = out_valid_q && bus.out_ready;
  assign last_fire = out_fire && out_last_q;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pixel = out_pixel_q;
  assign bus.out_last  = out_last_q;
  assign bus.err_index = err_q;

  // Next-state, window bookkeeping and next registered outputs
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    pix_d   = pix_q;
    idx_d   = idx_q;
    err_d   = err_q;
`ifdef MAX_UNPOOL_PREFETCH_EN
    pend_full_d = pend_full_q;
    pend_pix_d  = pend_pix_q;
    pend_idx_d  = pend_idx_q;
`endif

    // Out-of-range argmax is flagged at acceptance; the window then never matches pos
    if (in_fire && (32'(bus.in_index) >= WIN_SIZE)) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (in_fire) begin
          pix_d   = bus.in_pixel;
          idx_d   = bus.in_index;
          pos_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_fire) begin
          if (last_fire) begin
            pos_d = '0;
`ifdef MAX_UNPOOL_PREFETCH_EN
            if (pend_full_q) begin
              pix_d       = pend_pix_q;
              idx_d       = pend_idx_q;
              pend_full_d = 1'b0;
            end else if (in_fire) begin
              pix_d = bus.in_pixel;
              idx_d = bus.in_index;
            end else begin
              state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
          end else begin
            pos_d = pos_q + IDX_WIDTH'(1);
          end
        end
      end
    endcase

`ifdef MAX_UNPOOL_PREFETCH_EN
    // Input arriving mid-window parks in pending unless it went straight to active
    if (in_fire && (state_q == EMIT) && !(last_fire && !pend_full_q)) begin
      pend_pix_d  = bus.in_pixel;
      pend_idx_d  = bus.in_index;
      pend_full_d = 1'b1;
    end
`endif

    out_valid_d = (state_d == EMIT);
    out_pixel_d = (out_valid_d && (pos_d == idx_d)) ? pix_d : '0;
    out_last_d  = out_valid_d && (pos_d == IDX_WIDTH'(WIN_SIZE - 1));
`ifdef MAX_UNPOOL_PREFETCH_EN
    in_ready_d  = !pend_full_d;
`else
    in_ready_d  = (state_d == IDLE);
`endif
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      pix_q       <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef MAX_UNPOOL_PREFETCH_EN
      pend_full_q <= 1'b0;
      pend_pix_q  <= '0;
      pend_idx_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      pix_q       <= pix_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= in_ready_d;
`ifdef MAX_UNPOOL_PREFETCH_EN
      pend_full_q <= pend_full_d;
      pend_pix_q  <= pend_pix_d;
      pend_idx_q  <= pend_idx_d;
`endif
    end
  end
endmodule

// File: tb/tb_max_unpooling.sv
// Scoreboard bench for max_unpooling: a negedge monitor compares every output
// beat against windows expanded from accepted inputs by a simple array model.
module tb_max_unpooling;
  localparam int unsigned DW  = 8;
  localparam int unsigned KD  = 3;
  localparam int unsigned WIN = KD * KD;

  typedef struct packed {
    logic [DW-1:0] pix;
    logic          last;
  } beat_t;

  logic clk;
  logic rst;
  max_unpooling_if #(.DATA_WIDTH(DW), .KERNEL_DIM(KD)) bus ();

  max_unpooling #(.DATA_WIDTH(DW), .KERNEL_DIM(KD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  beat_t exp_q[$];
  logic err_exp = 1'b0;
  int rmode = 0;
  int cyc = 0;

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_pix;
  logic          prev_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Downstream ready pattern: 0 always ready, 1 = 1,0,0 repeating, 2 random
  always @(posedge clk) begin
    #1;
    cyc++;
    case (rmode)
      1:       bus.out_ready = (cyc % 3 == 0);
      2:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b1;
    endcase
  end

  // Monitor: check held beats under stall, pop/compare transfers, expand accepted inputs
  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
      err_exp    = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", 32'({bus.out_valid, bus.out_pixel, bus.out_last}),
              32'({1'b1, prev_pix, prev_last}));
      if (bus.out_valid && bus.out_ready) begin
        check("beat_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          check("beat", 32'({bus.out_pixel, bus.out_last}), 32'({b.pix, b.last}));
        end
      end else if (!bus.out_valid) begin
        check("idle_zero", 32'({bus.out_pixel, bus.out_last}), 32'(0));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_pix   = bus.out_pixel;
      prev_last  = bus.out_last;
      if (bus.in_valid && bus.in_ready) begin
        for (int p = 0; p < int'(WIN); p++) begin
          b.pix  = (p == int'(bus.in_index)) ? bus.in_pixel : '0;
          b.last = (p == int'(WIN) - 1);
          exp_q.push_back(b);
        end
        if (int'(bus.in_index) >= int'(WIN)) err_exp = 1'b1;
      end
    end
  end

  // Present one input and hold it until accepted; returns just after the accepting edge
  task automatic send(input logic [DW-1:0] p, input logic [3:0] idx);
    bit ok = 0;
    bus.in_pixel = p;
    bus.in_index = idx;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
      end
    end
    check("in_accept", 32'(ok), 32'(1));
  endtask

  // Wait for all expected beats to be consumed, then confirm the block went idle
  task automatic drain(input string name);
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(negedge clk);
    check(name, 32'(exp_q.size()), 32'(0));
    @(negedge clk);
    check("idle_after_window", 32'(bus.out_valid), 32'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [19:0] v;
    logic [19:0] v_exp;

    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pixel  = '0;
    bus.in_index  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_out_pixel", 32'(bus.out_pixel), 32'(0));
    check("rst_out_last", 32'(bus.out_last), 32'(0));
    check("rst_err", 32'(bus.err_index), 32'(0));
    @(posedge clk);
    #1;

    // Single window, value 9 at slot 4
    rmode = 0;
    send(8'd9, 4'd4);
    bus.in_valid = 1'b0;
    check("first_beat_latency", 32'({bus.out_valid, bus.out_pixel}), 32'({1'b1, 8'd0}));
    drain("single_drain");

    // Backpressure with 1,0,0 ready pattern
    rmode = 1;
    send(8'd200, 4'd0);
    bus.in_valid = 1'b0;
    drain("backpressure_drain");
    rmode = 0;

    // Out-of-range index, then a valid window with argmax at the last slot
    send(8'd55, 4'd12);
    bus.in_valid = 1'b0;
    drain("bad_index_drain");
    check("err_set", 32'(bus.err_index), 32'(1));
    send(8'd7, 4'd8);
    bus.in_valid = 1'b0;
    drain("after_bad_drain");
    check("err_sticky", 32'(bus.err_index), 32'(1));

    // Reset after beat 3 of a window
    send(8'd77, 4'd5);
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'(0));
    check("midrst_out_bus", 32'({bus.out_pixel, bus.out_last}), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("midrst_err_clear", 32'(bus.err_index), 32'(err_exp));
    check("midrst_in_ready", 32'(bus.in_ready), 32'(1));
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    send(8'd33, 4'd2);
    bus.in_valid = 1'b0;
    drain("post_rst_drain");

    // Back-to-back windows with in_valid held high
    send(8'd10, 4'd1);
    fork
      begin
        send(8'd20, 4'd7);
        bus.in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          v[i] = bus.out_valid;
        end
      end
    join
    v_exp = '0;
`ifdef MAX_UNPOOL_PREFETCH_EN
    for (int i = 0; i < 18; i++) v_exp[i] = 1'b1;
`else
    for (int i = 0; i < 9; i++) v_exp[i] = 1'b1;
    for (int i = 10; i < 19; i++) v_exp[i] = 1'b1;
`endif
    check("b2b_valid_pattern", 32'(v), 32'(v_exp));
    drain("b2b_drain");

    // Randomized windows under random backpressure and random input gaps
    rmode = 2;
    for (int w = 0; w < 25; w++) begin
      send(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 12)) @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    drain("random_drain");
    rmode = 0;
    check("random_err", 32'(bus.err_index), 32'(err_exp));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
